// File: rtl/pa_f_spsram_ctrl_64x44_pkg.sv
// Shared definitions for the 64x44 single-port SRAM controller:
// FSM state encoding and the idle levels of the macro control pins.
package pa_f_spsram_ctrl_64x44_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_INIT = 2'b01,
        ST_RUN  = 2'b10
    } ctrl_state_e;

    // Macro control pins are active low, so idle means driven high
    localparam logic SRAM_CEN_IDLE     = 1'b1;
    localparam logic SRAM_GWEN_IDLE    = 1'b1;
    localparam logic SRAM_WEN_IDLE_BIT = 1'b1;

endpackage

// File: rtl/pa_f_spsram_ctrl_64x44_if.sv
// Request/response bus of the SRAM controller. The master issues
// requests and accepts responses; the slave is the controller.
interface pa_f_spsram_ctrl_64x44_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 44
) ();

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );

endinterface

// File: rtl/pa_f_spsram_ctrl_rsp_hold.sv
// One-entry read response stage. In the cycle after a read the macro Q
// is passed straight through; if the consumer stalls, Q is kept in a
// hold register so the presented data stays stable until accepted.
module pa_f_spsram_ctrl_rsp_hold #(
    parameter int DATA_WIDTH = 44
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  rd_accept,
    input  logic                  rsp_rdy,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    logic                  rd_pend_q;
    logic                  rd_pend_d;
    logic                  hold_vld_q;
    logic                  hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;

    // Present Q directly right after the read, the held copy afterwards
    always_comb begin
        rsp_vld = rd_pend_q | hold_vld_q;
        if (rd_pend_q) begin
            rsp_rdata = sram_q;
        end else if (hold_vld_q) begin
            rsp_rdata = hold_q;
        end else begin
            rsp_rdata = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state: capture Q while it is valid, keep the entry on a stall
    always_comb begin
        rd_pend_d  = 1'b0;
        hold_vld_d = 1'b0;
        hold_d     = hold_q;
        if (rd_pend_q) begin
            hold_d = sram_q;
        end else begin
            hold_d = hold_q;
        end
        if (flush) begin
            rd_pend_d  = 1'b0;
            hold_vld_d = 1'b0;
        end else begin
            rd_pend_d  = rd_accept;
            hold_vld_d = rsp_vld & ~rsp_rdy;
        end
    end

    // Response state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_pend_q  <= rd_pend_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/pa_f_spsram_ctrl_64x44.sv
// Initiator-side controller for a 64x44 single-port SRAM macro.
// After reset (and on init_req) every entry is swept to INIT_VALUE;
// afterwards valid/ready requests are turned into macro pin activity
// and read data is returned on the response port.
module pa_f_spsram_ctrl_64x44
    import pa_f_spsram_ctrl_64x44_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 44,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    init_req,
    output logic                    init_done,
    pa_f_spsram_ctrl_64x44_if.slave bus,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    ctrl_state_e           state_q;
    ctrl_state_e           state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  flush_s;
    logic                  run_s;
    logic                  req_rdy_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  rsp_vld_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_s;

    // FSM next-state and sweep counter; init_req only matters in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_s = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
            ST_INIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                    flush_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Handshake: a restart request blocks acceptance in the same cycle
    always_comb begin
        run_s       = (state_q == ST_RUN);
        req_rdy_s   = run_s & ~init_req & (~rsp_vld_s | bus.rsp_rdy);
        wr_accept_s = req_rdy_s & bus.req_vld & bus.req_wr;
        rd_accept_s = req_rdy_s & bus.req_vld & ~bus.req_wr;
    end

    // Macro pin drive: sweep write, accepted write, accepted read or idle
    always_comb begin
        sram_cen  = SRAM_CEN_IDLE;
        sram_gwen = SRAM_GWEN_IDLE;
        sram_wen  = {DATA_WIDTH{SRAM_WEN_IDLE_BIT}};
        sram_a    = {ADDR_WIDTH{1'b0}};
        sram_d    = {DATA_WIDTH{1'b0}};
        if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = {DATA_WIDTH{1'b0}};
            sram_a    = cnt_q;
            sram_d    = INIT_VALUE;
        end else if (wr_accept_s) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~bus.req_wmask;
            sram_a    = bus.req_addr;
            sram_d    = bus.req_wdata;
        end else if (rd_accept_s) begin
            sram_cen  = 1'b0;
            sram_a    = bus.req_addr;
        end else begin
            sram_cen  = SRAM_CEN_IDLE;
        end
    end

    // FSM state and sweep counter registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_RST;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pa_f_spsram_ctrl_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .flush     (flush_s),
        .rd_accept (rd_accept_s),
        .rsp_rdy   (bus.rsp_rdy),
        .sram_q    (sram_q),
        .rsp_vld   (rsp_vld_s),
        .rsp_rdata (rsp_rdata_s)
    );

    assign init_done     = run_s;
    assign bus.req_rdy   = req_rdy_s;
    assign bus.rsp_vld   = rsp_vld_s;
    assign bus.rsp_rdata = rsp_rdata_s;

endmodule

// File: tb/tb_pa_f_spsram_ctrl_64x44.sv
// Self-checking bench for pa_f_spsram_ctrl_64x44: behavioural SRAM macro,
// an array reference memory, and a scoreboard queue of expected read data
// consumed by an independent response monitor.
module tb_pa_f_spsram_ctrl_64x44;

    localparam int AW    = 6;
    localparam int DW    = 44;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] INIT_V = 44'h0;
    localparam logic [DW-1:0] ONES   = {DW{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          init_req;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    pa_f_spsram_ctrl_64x44_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    pa_f_spsram_ctrl_64x44 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE (INIT_V)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .init_req       (init_req),
        .init_done      (init_done),
        .bus            (bus_if),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    logic [DW-1:0] macro_mem [DEPTH];
    logic [DW-1:0] ref_mem   [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            last_stall;
    logic          last_rsp_vld;
    logic [DW-1:0] last_wen;
    logic          rand_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: active-low controls, per-bit WEN, Q one cycle later
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= macro_mem[sram_a];
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] <= DW'({$urandom, $urandom});
        sram_q <= DW'({$urandom, $urandom});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every accepted response
    initial begin
        logic          held_prev;
        logic [DW-1:0] held_data;
        logic [DW-1:0] exp;
        held_prev = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_prev && bus_if.rsp_vld)
                    chk("hold_stable", 128'(bus_if.rsp_rdata), 128'(held_data));
                if (bus_if.rsp_vld && bus_if.rsp_rdy) begin
                    chk("rsp_expected", 128'(exp_q.size() != 0), 128'(1'b1));
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        chk("rsp_data", 128'(bus_if.rsp_rdata), 128'(exp));
                    end
                end
                held_prev = bus_if.rsp_vld & ~bus_if.rsp_rdy;
                held_data = bus_if.rsp_rdata;
            end else begin
                held_prev = 1'b0;
            end
        end
    end

    // Random consumer back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus_if.rsp_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one request and wait (bounded) until it is accepted
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        bus_if.req_vld   = 1'b1;
        bus_if.req_wr    = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        bus_if.req_wmask = wm;
        last_stall = 0;
        @(negedge clk);
        while (!bus_if.req_rdy && last_stall < 60) begin
            last_stall++;
            @(negedge clk);
        end
        chk("req_accept", 128'(bus_if.req_rdy), 128'(1'b1));
        if (bus_if.req_rdy) begin
            last_wen     = sram_wen;
            last_rsp_vld = bus_if.rsp_vld;
            if (wr) ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
            else    exp_q.push_back(ref_mem[addr]);
            @(posedge clk);
            #1;
        end else begin
            bus_if.req_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bus_if.req_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_pins"}, 128'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            128'({1'b1, 1'b1, ONES, {AW{1'b0}}, {DW{1'b0}}}));
        chk({name, "_out"}, 128'({init_done, bus_if.req_rdy, bus_if.rsp_vld, bus_if.rsp_rdata}),
            128'({1'b0, 1'b0, 1'b0, {DW{1'b0}}}));
    endtask

    // Expect a full 64-entry sweep starting now, then init_done
    task automatic sweep_check(input string name);
        logic [AW-1:0] a_exp;
        for (int k = 0; k < DEPTH; k++) begin
            a_exp = AW'(k);
            @(negedge clk);
            chk({name, "_pins"}, 128'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
                128'({1'b0, 1'b0, {DW{1'b0}}, a_exp, INIT_V}));
            chk({name, "_flags"}, 128'({init_done, bus_if.req_rdy, bus_if.rsp_vld}), 128'(3'b000));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({name, "_done"}, 128'({init_done, bus_if.req_rdy}), 128'(2'b11));
        chk({name, "_idle"}, 128'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            128'({1'b1, 1'b1, ONES, {AW{1'b0}}, {DW{1'b0}}}));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_V;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [DW-1:0] rm;
        logic [DW-1:0] exp_a;
        int            r;

        rst_n            = 1'b0;
        init_req         = 1'b0;
        bus_if.req_vld   = 1'b0;
        bus_if.req_wr    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.req_wmask = '0;
        bus_if.rsp_rdy   = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset values, one RST cycle, then the power-on sweep
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_cycle");
        @(posedge clk);
        #1;
        sweep_check("sweep0");

        // Swept entries read back as the init value
        issue(1'b0, 6'd0, '0, '0);
        issue(1'b0, 6'd31, '0, '0);
        issue(1'b0, 6'd63, '0, '0);
        idle(3);

        // Full write then read of the same entry on the next cycle
        issue(1'b1, 6'd5, 44'hABC_DEF0_1234, ONES);
        issue(1'b0, 6'd5, '0, '0);
        bus_if.req_vld = 1'b0;
        @(negedge clk);
        chk("rd_latency", 128'(bus_if.rsp_vld), 128'(1'b1));
        @(posedge clk);
        #1;

        // Partial write under a low-half mask, and a write with empty mask
        issue(1'b1, 6'd7, 44'hFFF_FFFF_FFFF, ONES);
        issue(1'b1, 6'd7, 44'h0, 44'h000_0000_FFFF);
        chk("partial_wen", 128'(last_wen), 128'(44'hFFF_FFFF_0000));
        issue(1'b0, 6'd7, '0, '0);
        issue(1'b1, 6'd9, 44'h123_4567_89AB, ONES);
        issue(1'b1, 6'd9, 44'hFED_CBA9_8765, 44'h0);
        chk("zero_mask_wen", 128'(last_wen), 128'(ONES));
        issue(1'b0, 6'd9, '0, '0);
        idle(3);

        // Back-to-back reads at full throughput
        issue(1'b0, 6'd1, '0, '0);
        issue(1'b0, 6'd2, '0, '0);
        chk("b2b_stall2", 128'(last_stall), 128'(0));
        chk("b2b_rsp2", 128'(last_rsp_vld), 128'(1'b1));
        issue(1'b0, 6'd3, '0, '0);
        chk("b2b_stall3", 128'(last_stall), 128'(0));
        chk("b2b_rsp3", 128'(last_rsp_vld), 128'(1'b1));
        idle(3);

        // Held response: stable data, no acceptance, release takes a new read
        issue(1'b0, 6'd5, '0, '0);
        exp_a = ref_mem[5];
        bus_if.rsp_rdy   = 1'b0;
        bus_if.req_wr    = 1'b0;
        bus_if.req_addr  = 6'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rdy", 128'({bus_if.req_rdy, bus_if.rsp_vld}), 128'(2'b01));
            chk("hold_data", 128'(bus_if.rsp_rdata), 128'(exp_a));
            @(posedge clk);
            #1;
        end
        bus_if.rsp_rdy = 1'b1;
        issue(1'b0, 6'd7, '0, '0);
        chk("hold_release_stall", 128'(last_stall), 128'(0));
        idle(3);

        // init_req while a response is pending: blocked, dropped, swept again
        issue(1'b1, 6'd12, 44'h5A5_A5A5_A5A5, ONES);
        issue(1'b0, 6'd12, '0, '0);
        bus_if.rsp_rdy  = 1'b0;
        init_req        = 1'b1;
        bus_if.req_vld  = 1'b1;
        bus_if.req_addr = 6'd12;
        @(negedge clk);
        chk("initreq_block", 128'({bus_if.req_rdy, bus_if.rsp_vld}), 128'(2'b01));
        @(posedge clk);
        #1;
        init_req       = 1'b0;
        bus_if.req_vld = 1'b0;
        bus_if.rsp_rdy = 1'b1;
        exp_q.delete();
        sweep_check("sweep1");
        issue(1'b0, 6'd12, '0, '0);
        issue(1'b0, 6'd5, '0, '0);
        issue(1'b0, 6'd7, '0, '0);
        idle(3);

        // Reset asserted mid-sweep at address 20, then sweep restarts at 0
        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("midsweep_addr", 128'({sram_cen, sram_a}), 128'({1'b0, 6'd20}));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midsweep_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_cycle2");
        @(posedge clk);
        #1;
        sweep_check("sweep2");

        // Randomised traffic with random consumer back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                idle(1);
            end else begin
                ra = AW'($urandom_range(0, 15));
                rd = DW'({$urandom, $urandom});
                case ($urandom_range(0, 3))
                    0:       rm = '0;
                    1:       rm = ONES;
                    default: rm = DW'({$urandom, $urandom});
                endcase
                issue(r > 5, ra, rd, rm);
            end
        end
        bus_if.req_vld = 1'b0;
        rand_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus_if.rsp_rdy = 1'b1;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_f_spsram_ctrl_64x44.md
Name: pa_f_spsram_ctrl_64x44

Overview:
- Initiator-side controller for a 64-entry x 44-bit single-port SRAM macro with pins A, CEN, GWEN, WEN, D and Q.
- Controls are active-low and WEN is a per-bit write enable. A read returns Q one cycle after the access.
- Converts a valid/ready request port into SRAM pin activity and returns read data on a valid/ready response port.
- After reset, and on software request, it sweeps all entries to a fixed init value.

Parameters:
- ADDR_WIDTH, 6, SRAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 44, SRAM data width.
- INIT_VALUE, 44'h0, value written to every entry during the init sweep.

Ports:
- forever_cpuclk  in  1  single clock.
- cpurst_b  in  1  asynchronous active-low reset.
- init_req  in  1  one-cycle pulse; restarts the init sweep.
- init_done  out  1  high when the sweep is complete and requests are accepted.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  entry index.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  1 = write this bit.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  response accepted.
- rsp_rdata  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  to macro A.
- sram_cen  out  1  to macro CEN, active low.
- sram_gwen  out  1  to macro GWEN, active low.
- sram_wen  out  DATA_WIDTH  to macro WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to macro D.
- sram_q  in  DATA_WIDTH  from macro Q.

Behaviour:
- Reset is asynchronous on cpurst_b low; the clock is forever_cpuclk. All state flops reset asynchronously.
- FSM states: RST, INIT, RUN. Reset state is RST with counter = 0.
  - RST -> INIT unconditionally on the first clock after reset release.
  - INIT -> RUN in the cycle the counter reaches 2^ADDR_WIDTH-1.
  - RUN -> INIT on init_req; counter is cleared and any pending response is dropped.
  - init_req in RST or INIT is ignored.
- Reset and idle pin values (RST state, and any idle cycle):
  - sram_cen=1, sram_gwen=1, sram_wen=all 1s, sram_a=0, sram_d=0.
  - init_done=0, req_rdy=0, rsp_vld=0, rsp_rdata=0.
- INIT state, every cycle:
  - sram_cen=0, sram_gwen=0, sram_wen=0, sram_a=counter, sram_d=INIT_VALUE.
  - Counter increments each cycle. The sweep takes 64 cycles, addresses 0..63 in order.
  - req_rdy=0 throughout.
- RUN state:
  - init_done=1.
  - req_rdy = !init_req & (!rsp_vld | rsp_rdy). This is combinational; init_req wins over a simultaneous req_vld.
- Accepted write (req_vld & req_rdy & req_wr), same cycle:
  - sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_a=req_addr, sram_d=req_wdata.
  - No response is generated.
  - A write with req_wmask=0 still drives CEN low but changes no bit.
- Accepted read, in cycle t:
  - sram_cen=0, sram_gwen=1, sram_wen=all 1s, sram_a=req_addr.
  - In cycle t+1, rsp_vld=1 and rsp_rdata=sram_q, passed through combinationally.
  - sram_q is also captured into a hold register in cycle t+1.
- Response held (rsp_rdy=0):
  - rsp_vld stays 1 and rsp_rdata comes from the hold register. Data must stay stable until accepted.
  - req_rdy=0 while held.
- Response accepted with a new read (rsp_rdy=1 and a new read accepted in the same cycle):
  - Back-to-back reads are supported, one per cycle, at full throughput.
- Write then read of the same address in consecutive cycles returns the new data.
- Bits read back under req_wmask=0 keep their old values.
- Outside accepted accesses, sram_cen=1 and the other SRAM pins take the idle values.
- Reset asserted mid-sweep or mid-response:
  - All outputs go immediately to their reset values.
  - The sweep restarts from address 0 after the next RST state.

Decomposition:
- Shared package holds:
  - the FSM state encoding (RST=2'b00, INIT=2'b01, RUN=2'b10);
  - the SRAM pin idle constants (CEN/GWEN idle = 1, WEN idle = all 1s).
- One sub-module, pa_f_spsram_ctrl_rsp_hold: the one-entry response hold register with the valid/ready logic and the sram_q/hold select.
- The top level keeps the FSM, the counter and the SRAM pin drive.

Test Plan:
- Reset release -> one RST cycle, then 64 INIT cycles writing addresses 0..63 with WEN=0 and D=0. init_done rises on cycle 66. Reads of addresses 0, 31 and 63 return 0.
- Write addr 5, data 44'hABC_DEF0_1234, mask all 1s; read addr 5 next cycle -> rsp_vld one cycle after the read, rsp_rdata=44'hABC_DEF0_1234.
- Partial write to addr 7 (after a full-mask write of 44'hFFF_FFFF_FFFF), data 0, mask 44'h0000000FFFF -> sram_wen=44'hFFFFFFF0000; readback = 44'hFFF_FFFF_0000.
- Reads of addr 1,2,3 on consecutive cycles with rsp_rdy=1 -> three responses on consecutive cycles, in order.
- Second read with rsp_rdy held 0 for 5 cycles -> req_rdy=0, rsp_rdata stable. On the rsp_rdy=1 cycle, req_rdy=1 and a new read is accepted that same cycle.
- init_req pulsed with req_vld=1 while a response is pending -> request not accepted, response dropped, 64-cycle sweep rerun, then prior data reads back as INIT_VALUE.
- cpurst_b asserted at sweep address 20 -> sram_cen=1 immediately; after release the sweep restarts at address 0.
